// File: rtl/txacl_ppbuf_multilt.sv
// rtl/txacl_ppbuf_multilt.sv - per-LT ACL TX ping-pong payload buffer with ARQN/FLOW driven bank swap
module txacl_ppbuf_multilt #(
    parameter int NLT   = 8,
    parameter int LTW   = 3,
    parameter int DEPTH = 88,
    parameter int AW    = 7
) (
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic [LTW-1:0]  bsm_lt,
    input  logic [AW-1:0]   bsm_addr,
    input  logic [31:0]     bsm_din,
    input  logic            bsm_we,
    input  logic            bsm_cs,
    input  logic            bsm_commit_p,
    input  logic            bsm_flush_p,
    input  logic            err_clr_p,
    input  logic [LTW-1:0]  tx_lt,
    input  logic            tx_packet_st_p,
    input  logic            py_datperiod,
    input  logic [12:0]     pybitcount,
    input  logic            ack_p,
    input  logic [LTW-1:0]  ack_lt,
    input  logic            ack_arqn,
    input  logic            ack_flow,
    output logic [31:0]     lnctrl_bufword,
    output logic            lnctrl_txpybitin,
    output logic            latchpyhead_p,
    output logic            txhasdata,
    output logic            txnewpy,
    output logic [NLT-1:0]  bufready,
    output logic [NLT-1:0]  fillbusy,
    output logic            wr_err,
    output logic [NLT-1:0]  flow_stop
);

    localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);
    localparam logic [7:0]  DEPTH_W = 8'(DEPTH);

    logic [31:0] mem [NLT][2][DEPTH];

    logic [NLT-1:0] sel_q, rdy0_q, rdy1_q, sent_q, fs_q;
    logic [NLT-1:0] sel_n, rdy0_n, rdy1_n, sent_n, fs_n;
    logic [NLT-1:0] rdy_act, rdy_fill;
    logic [NLT-1:0] commit_v, flush_v, ack_v, tx_v;
    logic           cm_err, wr_err_n;

    logic [LTW-1:0] txlt_q;
    logic           txsel_q;
    logic           tx_hd;

    logic           wr_req, wr_bank, wr_oor, wr_ok, wr_bad;
    logic [7:0]     rd_word;
    logic           rd_ok;

    // Per-LT bank occupancy seen from the active / fill side.
    assign rdy_act  = (sel_q & rdy1_q) | (~sel_q & rdy0_q);
    assign rdy_fill = (sel_q & rdy0_q) | (~sel_q & rdy1_q);
    assign bufready = rdy_act;
    assign fillbusy = rdy_fill;
    assign flow_stop = fs_q;

    assign commit_v = bsm_commit_p   ? (NLT'(1) << bsm_lt) : '0;
    assign flush_v  = bsm_flush_p    ? (NLT'(1) << bsm_lt) : '0;
    assign ack_v    = ack_p          ? (NLT'(1) << ack_lt) : '0;
    assign tx_v     = tx_packet_st_p ? (NLT'(1) << tx_lt)  : '0;

    assign wr_req  = bsm_cs & bsm_we;
    assign wr_bank = ~sel_q[bsm_lt];
    assign wr_oor  = {1'b0, bsm_addr} >= DEPTH_A;
    assign wr_ok   = wr_req & ~rdy_fill[bsm_lt] & ~wr_oor;
    assign wr_bad  = wr_req & (rdy_fill[bsm_lt] | wr_oor);

    assign tx_hd = rdy_act[tx_lt] & ~fs_q[tx_lt];

    always_ff @(posedge clk_6M) begin
        if (wr_ok)
            mem[bsm_lt][wr_bank][bsm_addr] <= bsm_din;
    end

    // Same-LT priority: flush over ack over commit over tx-start; all read pre-cycle state.
    always_comb begin
        sel_n  = sel_q;
        rdy0_n = rdy0_q;
        rdy1_n = rdy1_q;
        sent_n = sent_q;
        fs_n   = fs_q;
        cm_err = 1'b0;
        for (int i = 0; i < NLT; i++) begin
            if (flush_v[i]) begin
                rdy0_n[i] = 1'b0;
                rdy1_n[i] = 1'b0;
                sent_n[i] = 1'b0;
                fs_n[i]   = 1'b0;
            end else begin
                if (tx_v[i] && rdy_act[i] && !fs_q[i])
                    sent_n[i] = 1'b1;
                if (ack_v[i]) begin
                    fs_n[i] = ~ack_flow;
                    if (ack_arqn && sent_q[i]) begin
                        if (sel_q[i])
                            rdy1_n[i] = 1'b0;
                        else
                            rdy0_n[i] = 1'b0;
                        sent_n[i] = 1'b0;
                        sel_n[i]  = ~sel_q[i];
                    end
                end
                if (commit_v[i]) begin
                    if (rdy_fill[i]) begin
                        cm_err = 1'b1;
                    end else begin
                        if (sel_q[i])
                            rdy0_n[i] = 1'b1;
                        else
                            rdy1_n[i] = 1'b1;
                        // An empty LT promotes the fresh payload straight to active.
                        if (!rdy_act[i])
                            sel_n[i] = ~sel_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        wr_err_n = wr_err;
        if (wr_bad || cm_err)
            wr_err_n = 1'b1;
        else if (err_clr_p)
            wr_err_n = 1'b0;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            sel_q     <= '0;
            rdy0_q    <= '0;
            rdy1_q    <= '0;
            sent_q    <= '0;
            fs_q      <= '0;
            wr_err    <= 1'b0;
            txlt_q    <= '0;
            txsel_q   <= 1'b0;
            txhasdata <= 1'b0;
            txnewpy   <= 1'b0;
        end else begin
            sel_q  <= sel_n;
            rdy0_q <= rdy0_n;
            rdy1_q <= rdy1_n;
            sent_q <= sent_n;
            fs_q   <= fs_n;
            wr_err <= wr_err_n;
            if (tx_packet_st_p) begin
                txlt_q    <= tx_lt;
                txsel_q   <= sel_q[tx_lt];
                txhasdata <= tx_hd;
                txnewpy   <= tx_hd & ~sent_q[tx_lt];
            end
        end
    end

    assign rd_word = pybitcount[12:5];
    assign rd_ok   = py_datperiod & txhasdata & (rd_word < DEPTH_W);

    assign lnctrl_bufword   = rd_ok ? mem[txlt_q][txsel_q][rd_word[AW-1:0]] : 32'd0;
    assign lnctrl_txpybitin = lnctrl_bufword[pybitcount[4:0]];
    assign latchpyhead_p    = (pybitcount[12:5] == 8'd0) & (pybitcount[4:0] == 5'd4);

endmodule
